// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the execute-stage slice: ALUOp, ALU control and funct.
package alu_exec_unit_pkg;

  localparam int WIDTH_DEF = 32;

  // ALUOp values driven by the multicycle controller.
  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_OR    = 2'b11
  } alu_op_e;

  // ALU control codes; 011 and 101 are unused and produce zero.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_NOR = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  // R-type funct fields recognised by the decoder.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

endpackage

// File: rtl/alu_exec_unit_alu_core.sv
// Combinational ALU with zero flag. Arithmetic wraps modulo 2^WIDTH.
module alu_core
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic lt_signed;

  // A true signed compare rather than the sign of a-b, so SLT stays
  // correct when the subtraction overflows.
  assign lt_signed = ($signed(a) < $signed(b));

  // Select the operation result from the control code.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    result = '0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage slice of the multicycle MIPS CPU: ALU control decode, ALU,
// branch-condition gate and the ALUOut register.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             pc_wr_cond,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             branch_take,
  output logic [WIDTH-1:0] alu_out
);

  logic [WIDTH-1:0] alu_out_d;
  logic [WIDTH-1:0] alu_out_q;

  // Decode ALUOp and, for R-type instructions, the funct field.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      OP_ADD: alu_ctrl = ALU_ADD;
      OP_SUB: alu_ctrl = ALU_SUB;
      OP_OR:  alu_ctrl = ALU_OR;
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_NOR:  alu_ctrl = ALU_NOR;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a      (src_a),
    .b      (src_b),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .zero   (zero)
  );

  // Branch is taken in the same cycle as the beq compare; no clocking here.
  assign branch_take = pc_wr_cond & zero;

  // ALUOut next value: reset clears it, otherwise capture every cycle.
  always_comb begin
    alu_out_d = rst_n ? alu_result : '0;
  end

  // ALUOut register; reset is synchronous and folded into alu_out_d.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // its input before any of them update, independent of block ordering.
    alu_out_q <= alu_out_d;
  end

  assign alu_out = alu_out_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        pc_wr_cond;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic        branch_take;
  logic [31:0] alu_out;

  int total_cnt;
  int pass_cnt;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_op      (alu_op),
    .funct       (funct),
    .src_a       (src_a),
    .src_b       (src_b),
    .pc_wr_cond  (pc_wr_cond),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .zero        (zero),
    .branch_take (branch_take),
    .alu_out     (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // Drive a new operand set away from the clock edge, then let it settle.
  task automatic apply(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic cond);
    @(negedge clk);
    alu_op     = op;
    funct      = fn;
    src_a      = a;
    src_b      = b;
    pc_wr_cond = cond;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  sweep_fn  [7];
  logic [2:0]  sweep_ctl [7];
  logic [31:0] sweep_res [7];

  initial begin
    total_cnt  = 0;
    pass_cnt   = 0;
    rst_n      = 1'b0;
    alu_op     = 2'b00;
    funct      = 6'b000000;
    src_a      = 32'd5;
    src_b      = 32'd3;
    pc_wr_cond = 1'b0;

    // Reset held for two edges clears ALUOut despite live data.
    tick();
    tick();
    check("reset_alu_out", alu_out, 32'h0);
    check("reset_comb_result", alu_result, 32'h8);

    // Release reset: next edge captures 5+3.
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_alu_out", alu_out, 32'h8);

    // Fetch PC+4.
    apply(2'b00, 6'b000000, 32'h0000_0010, 32'h4, 1'b0);
    check("fetch_ctrl", {29'b0, alu_ctrl}, 32'h2);
    check("fetch_result", alu_result, 32'h14);
    check("fetch_alu_out_before_edge", alu_out, 32'h8);
    tick();
    check("fetch_alu_out", alu_out, 32'h14);

    // R-type sweep with a=0xC, b=0xA.
    sweep_fn[0] = 6'b100000; sweep_ctl[0] = 3'b010; sweep_res[0] = 32'h0000_0016;
    sweep_fn[1] = 6'b100010; sweep_ctl[1] = 3'b110; sweep_res[1] = 32'h0000_0002;
    sweep_fn[2] = 6'b100100; sweep_ctl[2] = 3'b000; sweep_res[2] = 32'h0000_0008;
    sweep_fn[3] = 6'b100101; sweep_ctl[3] = 3'b001; sweep_res[3] = 32'h0000_000E;
    sweep_fn[4] = 6'b100111; sweep_ctl[4] = 3'b100; sweep_res[4] = 32'hFFFF_FFF1;
    sweep_fn[5] = 6'b101010; sweep_ctl[5] = 3'b111; sweep_res[5] = 32'h0000_0000;
    sweep_fn[6] = 6'b000000; sweep_ctl[6] = 3'b010; sweep_res[6] = 32'h0000_0016;
    for (int i = 0; i < 7; i++) begin
      apply(2'b10, sweep_fn[i], 32'h0000_000C, 32'h0000_000A, 1'b0);
      check($sformatf("rtype_ctrl_%0d", i), {29'b0, alu_ctrl}, {29'b0, sweep_ctl[i]});
      check($sformatf("rtype_result_%0d", i), alu_result, sweep_res[i]);
      check($sformatf("rtype_zero_%0d", i), {31'b0, zero}, {31'b0, (sweep_res[i] == 32'h0)});
    end
    tick();
    check("rtype_alu_out_latency", alu_out, 32'h0000_0016);

    // Signed SLT, including the overflowing subtraction case.
    apply(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("slt_neg1_lt_1", alu_result, 32'h1);
    apply(2'b10, 6'b101010, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    check("slt_min_lt_max", alu_result, 32'h1);
    apply(2'b10, 6'b101010, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    check("slt_max_lt_min", alu_result, 32'h0);
    check("slt_max_lt_min_zero", {31'b0, zero}, 32'h1);

    // Branch condition.
    apply(2'b01, 6'b000000, 32'h0000_1234, 32'h0000_1234, 1'b1);
    check("beq_eq_ctrl", {29'b0, alu_ctrl}, 32'h6);
    check("beq_eq_zero", {31'b0, zero}, 32'h1);
    check("beq_eq_take", {31'b0, branch_take}, 32'h1);
    apply(2'b01, 6'b000000, 32'h0000_1234, 32'h0000_1235, 1'b1);
    check("beq_ne_zero", {31'b0, zero}, 32'h0);
    check("beq_ne_take", {31'b0, branch_take}, 32'h0);
    apply(2'b01, 6'b000000, 32'h0000_1234, 32'h0000_1234, 1'b0);
    check("beq_nocond_zero", {31'b0, zero}, 32'h1);
    check("beq_nocond_take", {31'b0, branch_take}, 32'h0);

    // Wrap-around in both directions.
    apply(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("wrap_add_result", alu_result, 32'h0);
    check("wrap_add_zero", {31'b0, zero}, 32'h1);
    apply(2'b01, 6'b000000, 32'h0000_0000, 32'h0000_0001, 1'b0);
    check("wrap_sub_result", alu_result, 32'hFFFF_FFFF);
    check("wrap_sub_zero", {31'b0, zero}, 32'h0);
    tick();
    check("wrap_sub_alu_out", alu_out, 32'hFFFF_FFFF);

    // ALUOp=11 forces OR.
    apply(2'b11, 6'b100010, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    check("op_or_ctrl", {29'b0, alu_ctrl}, 32'h1);
    check("op_or_result", alu_result, 32'h0000_00FF);

    // Mid-operation reset clears only ALUOut; combinational path unaffected.
    apply(2'b01, 6'b000000, 32'h0000_0007, 32'h0000_0007, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_result", alu_result, 32'h0);
    check("midrst_take", {31'b0, branch_take}, 32'h1);
    tick();
    check("midrst_alu_out", alu_out, 32'h0);
    check("midrst_ctrl", {29'b0, alu_ctrl}, 32'h6);
    @(negedge clk);
    rst_n = 1'b1;
    alu_op = 2'b00;
    tick();
    check("midrst_release_alu_out", alu_out, 32'h0000_000E);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
